multi_synth: RTL

MULTI_SYNTH -- requirements
Module: multi_synth

---
 rtl/multi_synth_pkg.sv | 26 ++
 rtl/synth_wave.sv | 33 +++
 rtl/multi_synth.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/multi_synth_pkg.sv
// Shared constants for the multi-channel tone synthesizer: sequencer
// state codes, register-select codes, waveform mode codes and a width helper.
package multi_synth_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic [1:0] REG_SCALE     = 2'd0;
    localparam logic [1:0] REG_MODE      = 2'd1;
    localparam logic [1:0] REG_DUTY      = 2'd2;
    localparam logic [1:0] REG_PHASE_CLR = 2'd3;

    localparam logic [1:0] MODE_SQUARE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_PULSE  = 2'd3;

    // Channel-index width; a single channel still needs one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/synth_wave.sv
// Combinational phase-to-sample shaper, shared by all channels.
module synth_wave
    import multi_synth_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [OUT_W-1:0] phase,
    input  logic [1:0]       mode,
    input  logic [OUT_W-1:0] duty,
    input  logic             enable,
    output logic [OUT_W-1:0] sample
);

    logic [OUT_W-1:0] phase_dbl;

    assign phase_dbl = phase << 1;

    // Select the waveform; a silent channel (enable low) always yields zero.
    always_comb begin
        // NOTE: default assignment first so no path leaves sample unassigned (no latch).
        sample = '0;
        if (enable) begin
            case (mode)
                MODE_SQUARE: sample = phase[OUT_W-1] ? '1 : '0;
                MODE_SAW:    sample = phase;
                MODE_TRI:    sample = phase[OUT_W-1] ? ~phase_dbl : phase_dbl;
                MODE_PULSE:  sample = (phase < duty) ? '1 : '0;
                default:     sample = '0;
            endcase
        end
    end

endmodule

// File: rtl/multi_synth.sv
// Multi-channel DDS tone synthesizer. Each tick the sequencer walks all
// channels one per cycle, advancing each phase accumulator and summing the
// shaped samples through one shared synth_wave instance.
module multi_synth
    import multi_synth_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int ACC_W = 32,
    parameter  int OUT_W = 8,
    localparam int CH_W  = ch_width(NCH),
    localparam int SUM_W = OUT_W + CH_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_chan,
    input  logic [1:0]       wr_reg,
    input  logic [ACC_W-1:0] wr_data,
    input  logic             overrun_clr,
    output logic [NCH-1:0]   sq_out,
    output logic [SUM_W-1:0] mix_out,
    output logic             mix_valid,
    output logic             busy,
    output logic             overrun
);

    logic [ACC_W-1:0] acc   [NCH];
    logic [ACC_W-1:0] scale [NCH];
    logic [1:0]       mode  [NCH];
    logic [OUT_W-1:0] duty  [NCH];

    state_t           state;
    logic [CH_W-1:0]  idx;
    logic [SUM_W-1:0] sum;

    logic             running;
    logic             wr_hit;
    logic [ACC_W-1:0] acc_next;
    logic [OUT_W-1:0] sample;

    assign running  = (state == ST_RUN);
    assign busy     = (state != ST_IDLE);
    assign wr_hit   = wr_en && (int'(wr_chan) < NCH);
    // Adding a zero scale leaves the accumulator unchanged by construction.
    assign acc_next = acc[idx] + scale[idx];

    synth_wave #(
        .OUT_W (OUT_W)
    ) u_wave (
        .phase  (acc_next[ACC_W-1 -: OUT_W]),
        .mode   (mode[idx]),
        .duty   (duty[idx]),
        .enable (scale[idx] != '0),
        .sample (sample)
    );

    // Sequencer: accept a tick in IDLE, visit every channel, publish the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            sum       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            mix_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state <= ST_RUN;
                        idx   <= '0;
                        sum   <= '0;
                    end
                end
                ST_RUN: begin
                    sum <= sum + SUM_W'(sample);
                    idx <= idx + 1'b1;
                    if (idx == CH_W'(NCH - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    mix_out   <= sum;
                    mix_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky overrun: a tick arriving while busy is dropped and flagged; set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (tick && busy) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // Per-channel registers: accumulate the active channel, apply host writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this register file is small and must start silent, so it
            // is reset like ordinary flops rather than left as uninitialised RAM.
            for (int i = 0; i < NCH; i++) begin
                acc[i]   <= '0;
                scale[i] <= '0;
                mode[i]  <= '0;
                duty[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (running && idx == CH_W'(i)) begin
                    acc[i] <= acc_next;
                end
                // Placed after the accumulate so a phase clear wins the same edge.
                if (wr_hit && wr_chan == CH_W'(i)) begin
                    case (wr_reg)
                        REG_SCALE:     scale[i] <= wr_data;
                        REG_MODE:      mode[i]  <= wr_data[1:0];
                        REG_DUTY:      duty[i]  <= wr_data[OUT_W-1:0];
                        REG_PHASE_CLR: acc[i]   <= '0;
                        default:       ;
                    endcase
                end
            end
        end
    end

    // Square outputs come straight from the accumulator MSBs, gated by a live scale.
    always_comb begin
        sq_out = '0;
        for (int i = 0; i < NCH; i++) begin
            sq_out[i] = acc[i][ACC_W-1] & (scale[i] != '0);
        end
    end

endmodule
